fractal_sync_node: RTL and testbench

- One binary-tree node of the fractal synchronization network. It directly consumes the barrier requests that the compute units (CU BFMs in DV) issue.
- Pairs requests from its two children (east/west) and resolves barriers at its own level locally.
- Forwards higher-level barriers as one aggregated request to its parent, and broadcasts parent responses back down to both children.

---
 rtl/fractal_sync_pkg.sv | 23 ++
 rtl/fractal_sync_pend_cnt.sv | 41 ++++
 rtl/fractal_sync_node.sv | 131 +++++++++++++
 tb/tb_fractal_sync_node.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fractal_sync_pkg.sv
// Shared types for the fractal synchronization tree: request/response
// payloads and the node FSM state encoding.
package fractal_sync_pkg;

    localparam int SYNC_LVL_W = 4;
    localparam int SYNC_ID_W  = 8;

    typedef struct packed {
        logic [SYNC_LVL_W-1:0] level;
        logic [SYNC_ID_W-1:0]  id;
    } sync_req_t;

    typedef struct packed {
        logic [SYNC_ID_W-1:0] id;
        logic                 err;
    } sync_resp_t;

    typedef enum logic {
        COLLECT = 1'b0,
        FWD     = 1'b1
    } sync_state_e;

endpackage

// File: rtl/fractal_sync_pend_cnt.sv
// Outstanding-forward counter: saturating up/down count with full/empty
// flags and a sticky underflow flag for decrements seen while empty.
module fractal_sync_pend_cnt #(
    parameter int MAX = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_inc,
    input  logic i_dec,
    output logic o_full,
    output logic o_empty,
    output logic o_underflow
);

    localparam int CNT_W = $clog2(MAX + 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_unf;
    logic             w_dec_ok;

    assign o_empty     = (r_cnt == '0);
    assign o_full      = (r_cnt == CNT_W'(MAX));
    assign o_underflow = r_unf;
    // A decrement while empty is a protocol error and must not wrap.
    assign w_dec_ok    = i_dec && !o_empty;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cnt <= '0;
            r_unf <= 1'b0;
        end else begin
            if (i_dec && o_empty)
                r_unf <= 1'b1;
            if (i_inc && !w_dec_ok && !o_full)
                r_cnt <= r_cnt + 1'b1;
            else if (w_dec_ok && !i_inc)
                r_cnt <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/fractal_sync_node.sv
// Binary-tree node of the fractal sync network: pairs east/west barrier
// requests, resolves its own level locally, forwards higher levels upward.
module fractal_sync_node
    import fractal_sync_pkg::*;
#(
    parameter int LVL_W       = SYNC_LVL_W,
    parameter int ID_W        = SYNC_ID_W,
    parameter int NODE_LEVEL  = 1,
    parameter int MAX_LEVEL   = 3,
    parameter int MAX_PENDING = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             e_req_valid_i,
    output logic             e_req_ready_o,
    input  logic [LVL_W-1:0] e_req_level_i,
    input  logic [ID_W-1:0]  e_req_id_i,
    input  logic             w_req_valid_i,
    output logic             w_req_ready_o,
    input  logic [LVL_W-1:0] w_req_level_i,
    input  logic [ID_W-1:0]  w_req_id_i,
    output logic             e_resp_valid_o,
    output logic [ID_W-1:0]  e_resp_id_o,
    output logic             e_resp_err_o,
    output logic             w_resp_valid_o,
    output logic [ID_W-1:0]  w_resp_id_o,
    output logic             w_resp_err_o,
    output logic             p_req_valid_o,
    input  logic             p_req_ready_i,
    output logic [LVL_W-1:0] p_req_level_o,
    output logic [ID_W-1:0]  p_req_id_o,
    input  logic             p_resp_valid_i,
    input  logic [ID_W-1:0]  p_resp_id_i,
    input  logic             p_resp_err_i,
    output logic             proto_err_o
);

    sync_state_e r_state, w_state_nxt;
    sync_req_t   r_fwd;
    sync_resp_t  r_e_resp, r_w_resp;
    logic        r_e_vld, r_w_vld;

    logic w_e_legal, w_w_legal, w_pair, w_same, w_local_ok;
    logic w_e_bad, w_w_bad, w_mis, w_loc, w_fwd;
    logic w_e_done, w_w_done, w_full, w_empty, w_presp, w_hs, w_unf;

    function automatic logic f_legal(input logic [LVL_W-1:0] lvl);
        return (lvl >= LVL_W'(NODE_LEVEL)) && (lvl <= LVL_W'(MAX_LEVEL)) &&
               !((NODE_LEVEL == MAX_LEVEL) && (lvl > LVL_W'(NODE_LEVEL)));
    endfunction

    assign w_e_legal  = f_legal(e_req_level_i);
    assign w_w_legal  = f_legal(w_req_level_i);
    assign w_pair     = e_req_valid_i && w_req_valid_i && w_e_legal && w_w_legal;
    assign w_same     = (e_req_level_i == w_req_level_i) && (e_req_id_i == w_req_id_i);
    // Any completion that answers a child next cycle yields to a parent response.
    assign w_local_ok = (r_state == COLLECT) && !p_resp_valid_i;
    assign w_e_bad    = w_local_ok && e_req_valid_i && !w_e_legal;
    assign w_w_bad    = w_local_ok && w_req_valid_i && !w_w_legal;
    assign w_mis      = w_local_ok && w_pair && !w_same;
    assign w_loc      = w_local_ok && w_pair && w_same && (e_req_level_i == LVL_W'(NODE_LEVEL));
    assign w_fwd      = (r_state == COLLECT) && w_pair && w_same &&
                        (e_req_level_i > LVL_W'(NODE_LEVEL)) && !w_full;

    assign w_e_done   = w_e_bad || w_mis || w_loc;
    assign w_w_done   = w_w_bad || w_mis || w_loc;
    assign w_presp    = p_resp_valid_i && !w_empty;
    assign w_hs       = (r_state == FWD) && p_req_ready_i;

    assign e_req_ready_o = w_e_done || w_fwd;
    assign w_req_ready_o = w_w_done || w_fwd;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            COLLECT: if (w_fwd) w_state_nxt = FWD;
            FWD:     if (p_req_ready_i) w_state_nxt = COLLECT;
            default: w_state_nxt = COLLECT;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= COLLECT;
            r_fwd    <= '0;
            r_e_vld  <= 1'b0;
            r_w_vld  <= 1'b0;
            r_e_resp <= '0;
            r_w_resp <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fwd) begin
                r_fwd.level <= e_req_level_i;
                r_fwd.id    <= e_req_id_i;
            end
            r_e_vld <= w_presp || w_e_done;
            r_w_vld <= w_presp || w_w_done;
            if (w_presp) begin
                r_e_resp.id <= p_resp_id_i;
                r_w_resp.id <= p_resp_id_i;
            end else begin
                if (w_e_done) r_e_resp.id <= e_req_id_i;
                if (w_w_done) r_w_resp.id <= w_req_id_i;
            end
            r_e_resp.err <= w_presp ? p_resp_err_i : (w_e_bad || w_mis);
            r_w_resp.err <= w_presp ? p_resp_err_i : (w_w_bad || w_mis);
        end
    end

    fractal_sync_pend_cnt #(.MAX(MAX_PENDING)) u_pend (
        .i_clk       (clk_i),
        .i_rst       (rst_i),
        .i_inc       (w_hs),
        .i_dec       (p_resp_valid_i),
        .o_full      (w_full),
        .o_empty     (w_empty),
        .o_underflow (w_unf)
    );

    assign e_resp_valid_o = r_e_vld;
    assign e_resp_id_o    = r_e_resp.id;
    assign e_resp_err_o   = r_e_resp.err;
    assign w_resp_valid_o = r_w_vld;
    assign w_resp_id_o    = r_w_resp.id;
    assign w_resp_err_o   = r_w_resp.err;
    assign p_req_valid_o  = (r_state == FWD);
    assign p_req_level_o  = r_fwd.level;
    assign p_req_id_o     = r_fwd.id;
    assign proto_err_o    = w_unf;

endmodule

// File: tb/tb_fractal_sync_node.sv
// Bench for fractal_sync_node: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against a rule-level model.
module tb_fractal_sync_node;

    localparam int LVL_W = 4;
    localparam int ID_W  = 8;
    localparam int NODE  = 1;
    localparam int MAXL  = 3;
    localparam int MAXP  = 4;

    logic             clk = 1'b0;
    logic             rst_i = 1'b1;
    logic             e_req_valid_i = 1'b0, w_req_valid_i = 1'b0;
    logic [LVL_W-1:0] e_req_level_i = '0, w_req_level_i = '0;
    logic [ID_W-1:0]  e_req_id_i = '0, w_req_id_i = '0;
    logic             p_req_ready_i = 1'b0;
    logic             p_resp_valid_i = 1'b0, p_resp_err_i = 1'b0;
    logic [ID_W-1:0]  p_resp_id_i = '0;
    logic             e_req_ready_o, w_req_ready_o;
    logic             e_resp_valid_o, w_resp_valid_o, e_resp_err_o, w_resp_err_o;
    logic [ID_W-1:0]  e_resp_id_o, w_resp_id_o, p_req_id_o;
    logic             p_req_valid_o, proto_err_o;
    logic [LVL_W-1:0] p_req_level_o;

    always #5 clk = ~clk;

    fractal_sync_node #(
        .LVL_W(LVL_W), .ID_W(ID_W), .NODE_LEVEL(NODE), .MAX_LEVEL(MAXL), .MAX_PENDING(MAXP)
    ) dut (
        .clk_i(clk), .rst_i(rst_i),
        .e_req_valid_i(e_req_valid_i), .e_req_ready_o(e_req_ready_o),
        .e_req_level_i(e_req_level_i), .e_req_id_i(e_req_id_i),
        .w_req_valid_i(w_req_valid_i), .w_req_ready_o(w_req_ready_o),
        .w_req_level_i(w_req_level_i), .w_req_id_i(w_req_id_i),
        .e_resp_valid_o(e_resp_valid_o), .e_resp_id_o(e_resp_id_o), .e_resp_err_o(e_resp_err_o),
        .w_resp_valid_o(w_resp_valid_o), .w_resp_id_o(w_resp_id_o), .w_resp_err_o(w_resp_err_o),
        .p_req_valid_o(p_req_valid_o), .p_req_ready_i(p_req_ready_i),
        .p_req_level_o(p_req_level_o), .p_req_id_o(p_req_id_o),
        .p_resp_valid_i(p_resp_valid_i), .p_resp_id_i(p_resp_id_i), .p_resp_err_i(p_resp_err_i),
        .proto_err_o(proto_err_o)
    );

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    bit               m_fwd = 0, m_proto = 0;
    int               m_pend = 0;
    logic [LVL_W-1:0] m_flvl = '0;
    logic [ID_W-1:0]  m_fid = '0;
    logic             x_ev = 0, x_eerr = 0, x_wv = 0, x_werr = 0, x_pv = 0, x_proto = 0;
    logic [ID_W-1:0]  x_eid = '0, x_wid = '0, x_pid = '0;
    logic [LVL_W-1:0] x_plvl = '0;

    function automatic bit legal(input logic [LVL_W-1:0] l);
        return (int'(l) >= NODE) && (int'(l) <= MAXL) && !(NODE == MAXL && int'(l) > NODE);
    endfunction

    always @(negedge clk) begin
        bit er, wr, eo, wo, eerr, werr, go, pair, same, deliver, hs;
        chk("e_resp_valid", e_resp_valid_o, x_ev);
        chk("w_resp_valid", w_resp_valid_o, x_wv);
        chk("e_resp_err", e_resp_err_o, x_eerr);
        chk("w_resp_err", w_resp_err_o, x_werr);
        if (x_ev) chk("e_resp_id", e_resp_id_o, x_eid);
        if (x_wv) chk("w_resp_id", w_resp_id_o, x_wid);
        chk("p_req_valid", p_req_valid_o, x_pv);
        if (x_pv) begin
            chk("p_req_level", p_req_level_o, x_plvl);
            chk("p_req_id", p_req_id_o, x_pid);
        end
        chk("proto_err", proto_err_o, x_proto);

        er = 0; wr = 0; eo = 0; wo = 0; eerr = 0; werr = 0; go = 0;
        pair = e_req_valid_i && w_req_valid_i && legal(e_req_level_i) && legal(w_req_level_i);
        same = (e_req_level_i == w_req_level_i) && (e_req_id_i == w_req_id_i);
        if (!m_fwd) begin
            if (!p_resp_valid_i) begin
                if (e_req_valid_i && !legal(e_req_level_i)) begin er = 1; eo = 1; eerr = 1; end
                if (w_req_valid_i && !legal(w_req_level_i)) begin wr = 1; wo = 1; werr = 1; end
                if (pair && !same) begin
                    er = 1; wr = 1; eo = 1; wo = 1; eerr = 1; werr = 1;
                end else if (pair && int'(e_req_level_i) == NODE) begin
                    er = 1; wr = 1; eo = 1; wo = 1;
                end
            end
            if (pair && same && int'(e_req_level_i) > NODE && m_pend < MAXP) begin
                er = 1; wr = 1; go = 1;
            end
        end
        if (!rst_i) begin
            chk("e_req_ready", e_req_ready_o, er);
            chk("w_req_ready", w_req_ready_o, wr);
        end

        if (rst_i) begin
            m_fwd = 0; m_proto = 0; m_pend = 0;
            x_ev = 0; x_wv = 0; x_eerr = 0; x_werr = 0; x_pv = 0; x_proto = 0;
        end else begin
            deliver = p_resp_valid_i && m_pend > 0;
            x_ev   = deliver || eo;
            x_wv   = deliver || wo;
            x_eid  = deliver ? p_resp_id_i : e_req_id_i;
            x_wid  = deliver ? p_resp_id_i : w_req_id_i;
            x_eerr = deliver ? p_resp_err_i : eerr;
            x_werr = deliver ? p_resp_err_i : werr;
            if (p_resp_valid_i && m_pend == 0) m_proto = 1;
            hs = m_fwd && p_req_ready_i;
            m_pend = m_pend + int'(hs) - int'(deliver);
            if (hs) m_fwd = 0;
            if (go) begin m_fwd = 1; m_flvl = e_req_level_i; m_fid = e_req_id_i; end
            x_pv = m_fwd; x_plvl = m_flvl; x_pid = m_fid; x_proto = m_proto;
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_e(input bit v, input int l, input int id);
        e_req_valid_i = v; e_req_level_i = LVL_W'(l); e_req_id_i = ID_W'(id);
    endtask

    task automatic set_w(input bit v, input int l, input int id);
        w_req_valid_i = v; w_req_level_i = LVL_W'(l); w_req_id_i = ID_W'(id);
    endtask

    function automatic int rand_lvl();
        case ($urandom_range(0, 7))
            0: return 0;
            1, 2: return 1;
            3, 4: return 2;
            5: return 3;
            6: return 4;
            default: return 15;
        endcase
    endfunction

    initial begin
        bit e_acc, w_acc;
        cyc(); cyc();
        rst_i = 0;
        #5;
        chk("rst e_resp_valid", e_resp_valid_o, 0);
        chk("rst w_resp_valid", w_resp_valid_o, 0);
        chk("rst e_resp_id", e_resp_id_o, 0);
        chk("rst p_req_valid", p_req_valid_o, 0);
        chk("rst p_req_level", p_req_level_o, 0);
        chk("rst p_req_id", p_req_id_o, 0);
        chk("rst proto_err", proto_err_o, 0);
        cyc();

        // local barrier
        set_e(1, 1, 'h2A); set_w(1, 1, 'h2A);
        #5; chk("local e_ready", e_req_ready_o, 1); chk("local w_ready", w_req_ready_o, 1);
        cyc(); set_e(0, 0, 0); set_w(0, 0, 0);
        #5; chk("local e_resp", {e_resp_valid_o, e_resp_err_o, e_resp_id_o}, {2'b10, 8'h2A});
        chk("local w_resp", {w_resp_valid_o, w_resp_err_o, w_resp_id_o}, {2'b10, 8'h2A});
        cyc();
        #5; chk("local pulse end", {e_resp_valid_o, w_resp_valid_o}, 0);
        cyc();

        // staggered arrival
        set_e(1, 1, 5);
        for (int k = 0; k < 7; k++) begin
            #5; chk("stagger e_ready held", e_req_ready_o, 0);
            cyc();
        end
        set_w(1, 1, 5);
        #5; chk("stagger both ready", {e_req_ready_o, w_req_ready_o}, 2'b11);
        cyc(); set_e(0, 0, 0); set_w(0, 0, 0);
        #5; chk("stagger resp", {e_resp_valid_o, w_resp_valid_o, e_resp_id_o}, {2'b11, 8'h05});
        cyc();

        // forward, stall, return, collision with a waiting local pair
        set_e(1, 2, 9); set_w(1, 2, 9); p_req_ready_i = 0;
        #5; chk("fwd accept", {e_req_ready_o, w_req_ready_o}, 2'b11);
        cyc(); set_e(1, 1, 1); set_w(1, 1, 1);
        for (int k = 0; k < 3; k++) begin
            #5; chk("fwd hold", {p_req_valid_o, p_req_level_o, p_req_id_o}, {1'b1, 4'd2, 8'h09});
            chk("fwd no accept", {e_req_ready_o, w_req_ready_o}, 0);
            cyc();
        end
        p_req_ready_i = 1;
        #5; chk("fwd hs valid", p_req_valid_o, 1);
        cyc(); p_req_ready_i = 0; p_resp_valid_i = 1; p_resp_id_i = 9; p_resp_err_i = 0;
        #5; chk("fwd done", p_req_valid_o, 0);
        chk("collision stall", {e_req_ready_o, w_req_ready_o}, 0);
        cyc(); p_resp_valid_i = 0;
        #5; chk("parent resp", {e_resp_valid_o, w_resp_valid_o, e_resp_err_o, w_resp_id_o}, {3'b110, 8'h09});
        chk("local after collision ready", {e_req_ready_o, w_req_ready_o}, 2'b11);
        cyc(); set_e(0, 0, 0); set_w(0, 0, 0);
        #5; chk("local after collision resp", {e_resp_valid_o, e_resp_id_o}, {1'b1, 8'h01});
        cyc();

        // mismatch and illegal
        set_e(1, 1, 3); set_w(1, 1, 4);
        #5; chk("mis ready", {e_req_ready_o, w_req_ready_o}, 2'b11);
        cyc(); set_e(1, 0, 7); set_w(0, 0, 0);
        #5; chk("mis e", {e_resp_valid_o, e_resp_err_o, e_resp_id_o}, {2'b11, 8'h03});
        chk("mis w", {w_resp_valid_o, w_resp_err_o, w_resp_id_o}, {2'b11, 8'h04});
        chk("illegal alone ready", {e_req_ready_o, w_req_ready_o}, 2'b10);
        cyc(); set_e(0, 0, 0);
        #5; chk("illegal e", {e_resp_valid_o, e_resp_err_o, e_resp_id_o}, {2'b11, 8'h07});
        chk("illegal w quiet", w_resp_valid_o, 0);
        cyc();

        // fill pending to MAX_PENDING
        p_req_ready_i = 1;
        for (int i = 0; i < MAXP; i++) begin
            set_e(1, 2, 'h10 + i); set_w(1, 2, 'h10 + i);
            #5; chk("fill accept", e_req_ready_o, 1);
            cyc(); set_e(0, 0, 0); set_w(0, 0, 0);
            #5; chk("fill fwd", {p_req_valid_o, p_req_id_o}, {1'b1, ID_W'('h10 + i)});
            cyc();
        end
        set_e(1, 3, 'h20); set_w(1, 3, 'h20);
        for (int k = 0; k < 3; k++) begin
            #5; chk("full held", {e_req_ready_o, w_req_ready_o}, 0);
            cyc();
        end
        p_resp_valid_i = 1; p_resp_id_i = 'h10; p_resp_err_i = 0;
        #5; chk("full still held", e_req_ready_o, 0);
        cyc(); p_resp_valid_i = 0;
        #5; chk("full freed ready", {e_req_ready_o, w_req_ready_o}, 2'b11);
        chk("full resp", {e_resp_valid_o, e_resp_id_o}, {1'b1, 8'h10});
        cyc(); set_e(0, 0, 0); set_w(0, 0, 0);
        #5; chk("full fwd5", {p_req_valid_o, p_req_level_o, p_req_id_o}, {1'b1, 4'd3, 8'h20});
        cyc(); p_req_ready_i = 0;
        for (int i = 0; i < MAXP; i++) begin
            p_resp_valid_i = 1; p_resp_id_i = ID_W'('h30 + i); p_resp_err_i = (i == 2);
            #5; cyc(); p_resp_valid_i = 0;
            #5; chk("drain resp", {w_resp_valid_o, w_resp_err_o, w_resp_id_o},
                    {1'b1, (i == 2) ? 1'b1 : 1'b0, ID_W'('h30 + i)});
            cyc();
        end

        // protocol error with nothing pending
        p_resp_valid_i = 1; p_resp_id_i = 'h55;
        #5; cyc(); p_resp_valid_i = 0;
        #5; chk("proto set", proto_err_o, 1); chk("proto ignored", e_resp_valid_o, 0);
        cyc(); cyc();
        #5; chk("proto sticky", proto_err_o, 1);
        cyc();

        // reset in the middle of a forward
        set_e(1, 2, 'h77); set_w(1, 2, 'h77);
        #5; cyc(); set_e(0, 0, 0); set_w(0, 0, 0);
        #5; chk("pre-reset fwd", p_req_valid_o, 1);
        cyc(); rst_i = 1;
        #5; cyc(); rst_i = 0;
        #5; chk("reset drops fwd", p_req_valid_o, 0); chk("reset clears proto", proto_err_o, 0);
        cyc();

        // randomized traffic
        e_acc = 0; w_acc = 0;
        for (int c = 0; c < 4000; c++) begin
            if (e_req_valid_i && e_acc) e_req_valid_i = 0;
            if (w_req_valid_i && w_acc) w_req_valid_i = 0;
            if (!e_req_valid_i && !w_req_valid_i && $urandom_range(0, 2) == 0) begin
                int l, id;
                l = (($urandom_range(0, 1) == 0) ? 1 : 2); id = $urandom_range(0, 3);
                set_e(1, l, id); set_w(1, l, id);
            end else begin
                if (!e_req_valid_i && $urandom_range(0, 3) == 0) begin
                    if (w_req_valid_i && $urandom_range(0, 1) == 1)
                        set_e(1, int'(w_req_level_i), int'(w_req_id_i));
                    else
                        set_e(1, rand_lvl(), $urandom_range(0, 3));
                end
                if (!w_req_valid_i && $urandom_range(0, 3) == 0) begin
                    if (e_req_valid_i && $urandom_range(0, 1) == 1)
                        set_w(1, int'(e_req_level_i), int'(e_req_id_i));
                    else
                        set_w(1, rand_lvl(), $urandom_range(0, 3));
                end
            end
            p_req_ready_i  = ($urandom_range(0, 2) != 0);
            p_resp_valid_i = (m_pend > 0) && ($urandom_range(0, 3) == 0);
            p_resp_id_i    = ID_W'($urandom);
            p_resp_err_i   = 1'($urandom_range(0, 1));
            #5;
            e_acc = e_req_ready_o; w_acc = w_req_ready_o;
            cyc();
        end
        set_e(0, 0, 0); set_w(0, 0, 0); p_resp_valid_i = 0;
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
